icache_tag_ctrl: RTL and testbench

- Lookup and miss-control stage in front of icache_tag_blockram: 128 sets x 4 ways x 18-bit tags.
- Accepts one fetch lookup at a time and drives the tag RAM read index. Compares the 4 returned tags against the request tag.
- Reports hit plus way, or runs a miss sequence: line-fill request, pseudo-LRU victim selection, tag write.
- Owns the per-way valid bits and PLRU state in flops; the tag RAM holds only tags.

---
 rtl/icache_tag_ctrl_if.sv | 44 ++++
 rtl/icache_tag_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_icache_tag_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_tag_ctrl_if.sv
// Bundles the icache_tag_ctrl handshake and tag-RAM signals.
//   slave  : the tag controller's view (drives responses, fill requests, RAM controls)
//   master : the surrounding fetch unit / memory / tag RAM view
// Signals:
//   req_valid/req_ready/req_addr         fetch lookup request
//   resp_valid/resp_hit/resp_way         one-cycle lookup result
//   fill_req_valid/ready/addr, fill_done line-fill handshake with memory
//   flush                                invalidate all ways
//   tag_r_index/tag_rdata                tag RAM read port (2-cycle latency)
//   tag_w_index/tag_wdata/tag_wr_en      tag RAM write port
interface icache_tag_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 18,
    parameter int unsigned IDX_W  = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  resp_valid;
    logic                  resp_hit;
    logic [1:0]            resp_way;
    logic                  fill_req_valid;
    logic [ADDR_W-1:0]     fill_req_addr;
    logic                  fill_req_ready;
    logic                  fill_done;
    logic                  flush;
    logic [IDX_W-1:0]      tag_r_index;
    logic [4*TAG_W-1:0]    tag_rdata;
    logic [IDX_W+1:0]      tag_w_index;
    logic [TAG_W-1:0]      tag_wdata;
    logic                  tag_wr_en;

    modport slave (
        input  req_valid, req_addr, fill_req_ready, fill_done, flush, tag_rdata,
        output req_ready, resp_valid, resp_hit, resp_way, fill_req_valid,
               fill_req_addr, tag_r_index, tag_w_index, tag_wdata, tag_wr_en
    );

    modport master (
        output req_valid, req_addr, fill_req_ready, fill_done, flush, tag_rdata,
        input  req_ready, resp_valid, resp_hit, resp_way, fill_req_valid,
               fill_req_addr, tag_r_index, tag_w_index, tag_wdata, tag_wr_en
    );
endinterface

// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag lookup and miss controller, 128 sets x 4 ways.
// Drives the tag RAM read index, compares the four returned tags against the
// request tag (qualified by per-way valid flops), and on a miss issues a
// line-fill request, picks a victim (first invalid way, else tree PLRU) and
// writes the new tag. Valid bits and PLRU state live in flops here.
// Ports:
//   clk  clock (also clocks the tag RAM)
//   rst  asynchronous active-high reset
//   bus  icache_tag_ctrl_if.slave: request/response, fill handshake, flush,
//        tag RAM read/write port
module icache_tag_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 18,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned OFF_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    icache_tag_ctrl_if.slave bus
);

    localparam int unsigned NSETS = 2 ** IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_CMP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_FILL_WR,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          victim_q, victim_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic [1:0]          resp_way_q, resp_way_d;

    logic [NSETS-1:0][3:0] valid_q;
    logic [NSETS-1:0][2:0] plru_q;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [3:0]          set_valid;
    logic [2:0]          set_plru;
    logic [3:0]          match;
    logic                hit;
    logic [1:0]          hit_way;
    logic [1:0]          miss_victim;

    logic                valid_we;
    logic                plru_we;
    logic [1:0]          plru_way;
    logic                clr_all;

    assign req_tag = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = bus.req_addr[OFF_W +: IDX_W];

    // Tree PLRU: b0 is the root; an access points each bit on its path away
    // from the accessed way.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] r;
        r    = bits;
        r[0] = ~way[1];
        if (!way[1]) begin
            r[1] = ~way[0];
        end else begin
            r[2] = ~way[0];
        end
        return r;
    endfunction

    // Tag compare and victim choice for the latched set.
    always_comb begin
        set_valid = valid_q[idx_q];
        set_plru  = plru_q[idx_q];
        match     = '0;
        for (int unsigned w = 0; w < 4; w++) begin
            match[w] = set_valid[w] && (bus.tag_rdata[w*TAG_W +: TAG_W] == tag_q);
        end
        hit = |match;

        // Lowest matching way wins should duplicates ever appear.
        casez (match)
            4'b???1: hit_way = 2'd0;
            4'b??10: hit_way = 2'd1;
            4'b?100: hit_way = 2'd2;
            4'b1000: hit_way = 2'd3;
            default: hit_way = 2'd0;
        endcase

        casez (set_valid)
            4'b???0: miss_victim = 2'd0;
            4'b??01: miss_victim = 2'd1;
            4'b?011: miss_victim = 2'd2;
            4'b0111: miss_victim = 2'd3;
            default: miss_victim = set_plru[0] ? {1'b1, set_plru[2]} : {1'b0, set_plru[1]};
        endcase
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        valid_we     = 1'b0;
        plru_we      = 1'b0;
        plru_way     = '0;
        clr_all      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    state_d = S_FLUSH;
                end else if (bus.req_valid) begin
                    tag_d   = req_tag;
                    idx_d   = req_idx;
                    state_d = S_RD1;
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: state_d = S_CMP;
            S_CMP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_way_d   = hit_way;
                    plru_we      = 1'b1;
                    plru_way     = hit_way;
                    state_d      = S_IDLE;
                end else begin
                    victim_d = miss_victim;
                    state_d  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (bus.fill_req_ready) begin
                    state_d = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (bus.fill_done) begin
                    state_d = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                valid_we     = 1'b1;
                plru_we      = 1'b1;
                plru_way     = victim_q;
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_way_d   = victim_q;
                state_d      = S_IDLE;
            end
            S_FLUSH: begin
                clr_all = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            idx_q        <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            if (valid_we) begin
                valid_q[idx_q][victim_q] <= 1'b1;
            end
            if (plru_we) begin
                plru_q[idx_q] <= plru_touch(plru_q[idx_q], plru_way);
            end
        end
    end

    // Address the RAM straight from the request in IDLE so the read starts
    // on the accept edge; afterwards hold the latched index.
    assign bus.tag_r_index    = (state_q == S_IDLE) ? req_idx : idx_q;
    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.fill_req_valid = (state_q == S_MISS_REQ);
    assign bus.fill_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
    assign bus.tag_wr_en      = (state_q == S_FILL_WR);
    assign bus.tag_w_index    = (state_q == S_FILL_WR) ? {idx_q, victim_q} : '0;
    assign bus.tag_wdata      = (state_q == S_FILL_WR) ? tag_q : '0;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_way       = resp_way_q;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Self-checking bench for icache_tag_ctrl: directed scenarios followed by
// random lookups, checked against a set-associative cache model that tracks
// valid/tag per way and the three PLRU tree bits per set.
module tb_icache_tag_ctrl;

    logic clk;
    logic rst;

    icache_tag_ctrl_if #(.ADDR_W(32), .TAG_W(18), .IDX_W(7)) bus_if ();

    icache_tag_ctrl #(.ADDR_W(32), .TAG_W(18), .IDX_W(7), .OFF_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM stand-in: 2-cycle read latency (index register, data register).
    logic [17:0] ram [128][4];
    logic [6:0]  ram_ridx;
    initial begin
        ram_ridx = '0;
        // Random stale tags, so a matching but invalid way must still miss.
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 4; w++)
                ram[s][w] = 18'($urandom_range(0, 5));
    end
    always @(posedge clk) begin
        if (bus_if.tag_wr_en)
            ram[bus_if.tag_w_index[8:2]][bus_if.tag_w_index[1:0]] <= bus_if.tag_wdata;
        ram_ridx <= bus_if.tag_r_index;
        bus_if.tag_rdata <= {ram[ram_ridx][3], ram[ram_ridx][2], ram[ram_ridx][1], ram[ram_ridx][0]};
    end

    // Reference cache model.
    bit          ref_valid [128][4];
    logic [17:0] ref_tag   [128][4];
    bit          ref_b0 [128];
    bit          ref_b1 [128];
    bit          ref_b2 [128];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < 128; s++) begin
            for (int w = 0; w < 4; w++) ref_valid[s][w] = 1'b0;
            ref_b0[s] = 1'b0;
            ref_b1[s] = 1'b0;
            ref_b2[s] = 1'b0;
        end
    endfunction

    function automatic void model_touch(input int s, input int w);
        ref_b0[s] = (w < 2);
        if (w < 2) ref_b1[s] = (w == 0);
        else       ref_b2[s] = (w == 2);
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!ref_valid[s][w]) return w;
        return ref_b0[s] ? 2 + int'(ref_b2[s]) : int'(ref_b1[s]);
    endfunction

    task automatic check_reset_outputs();
        check("rst_req_ready",   32'(bus_if.req_ready),      1);
        check("rst_resp_valid",  32'(bus_if.resp_valid),     0);
        check("rst_resp_hit",    32'(bus_if.resp_hit),       0);
        check("rst_resp_way",    32'(bus_if.resp_way),       0);
        check("rst_fill_valid",  32'(bus_if.fill_req_valid), 0);
        check("rst_fill_addr",   bus_if.fill_req_addr,       0);
        check("rst_tag_wr_en",   32'(bus_if.tag_wr_en),      0);
        check("rst_tag_w_index", 32'(bus_if.tag_w_index),    0);
        check("rst_tag_wdata",   32'(bus_if.tag_wdata),      0);
    endtask

    // One lookup; rdy_delay = cycles fill_req_ready stays low, abort = reset in MISS_WAIT.
    task automatic lookup(input logic [31:0] addr, input int rdy_delay, input bit abort);
        int s;
        logic [17:0] t;
        bit exp_hit;
        int exp_way;
        int n;
        logic [31:0] fa;
        s  = int'(addr[13:7]);
        t  = addr[31:14];
        fa = {addr[31:7], 7'b0};
        exp_hit = 1'b0;
        exp_way = 0;
        for (int w = 3; w >= 0; w--)
            if (ref_valid[s][w] && ref_tag[s][w] == t) begin
                exp_hit = 1'b1;
                exp_way = w;
            end
        if (!exp_hit) exp_way = model_victim(s);

        @(negedge clk);
        check("idle_req_ready",   32'(bus_if.req_ready),  1);
        check("resp_single_pulse", 32'(bus_if.resp_valid), 0);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = $urandom;

        if (exp_hit) begin
            for (int k = 1; k <= 4; k++) begin
                if (k > 1) @(negedge clk);
                check("hit_resp_timing", 32'(bus_if.resp_valid), 32'(k == 4));
                check("hit_no_fill",     32'(bus_if.fill_req_valid), 0);
            end
            check("hit_resp_hit",  32'(bus_if.resp_hit),  1);
            check("hit_resp_way",  32'(bus_if.resp_way),  32'(exp_way));
            check("hit_req_ready", 32'(bus_if.req_ready), 1);
            model_touch(s, exp_way);
            return;
        end

        n = 1;
        while (!bus_if.fill_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("miss_fill_latency", 32'(n), 4);
        check("miss_fill_addr",    bus_if.fill_req_addr, fa);
        check("miss_no_resp",      32'(bus_if.resp_valid), 0);
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            check("fill_valid_held", 32'(bus_if.fill_req_valid), 1);
            check("fill_addr_held",  bus_if.fill_req_addr, fa);
        end
        bus_if.fill_req_ready = 1'b1;
        @(negedge clk);
        bus_if.fill_req_ready = 1'b0;
        check("wait_fill_dropped", 32'(bus_if.fill_req_valid), 0);
        check("wait_not_ready",    32'(bus_if.req_ready), 0);

        if (abort) begin
            #2 rst = 1'b1;
            #1 check_reset_outputs();
            @(negedge clk);
            rst = 1'b0;
            model_clear();
            bus_if.fill_done = 1'b1;
            @(negedge clk);
            bus_if.fill_done = 1'b0;
            check("abort_done_ignored", 32'(bus_if.tag_wr_en), 0);
            @(negedge clk);
            check("abort_no_resp", 32'(bus_if.resp_valid), 0);
            return;
        end

        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("wait_no_write", 32'(bus_if.tag_wr_en), 0);
        end
        bus_if.fill_done = 1'b1;
        @(negedge clk);
        bus_if.fill_done = 1'b0;
        check("fill_wr_en",    32'(bus_if.tag_wr_en),   1);
        check("fill_w_index",  32'(bus_if.tag_w_index), 32'(s * 4 + exp_way));
        check("fill_wdata",    32'(bus_if.tag_wdata),   32'(t));
        check("fill_no_resp",  32'(bus_if.resp_valid),  0);
        @(negedge clk);
        check("miss_resp_valid", 32'(bus_if.resp_valid), 1);
        check("miss_resp_hit",   32'(bus_if.resp_hit),   0);
        check("miss_resp_way",   32'(bus_if.resp_way),   32'(exp_way));
        check("miss_wr_done",    32'(bus_if.tag_wr_en),  0);
        ref_valid[s][exp_way] = 1'b1;
        ref_tag[s][exp_way]   = t;
        model_touch(s, exp_way);
    endtask

    task automatic do_flush(input logic [31:0] addr);
        @(negedge clk);
        bus_if.flush     = 1'b1;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        @(negedge clk);
        bus_if.flush     = 1'b0;
        bus_if.req_valid = 1'b0;
        check("flush_busy", 32'(bus_if.req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("flush_req_dropped", 32'(bus_if.req_ready), 1);
            check("flush_no_fill",     32'(bus_if.fill_req_valid), 0);
            check("flush_no_resp",     32'(bus_if.resp_valid), 0);
        end
        model_clear();
    endtask

    task automatic stray_done();
        @(negedge clk);
        bus_if.fill_done = 1'b1;
        @(negedge clk);
        bus_if.fill_done = 1'b0;
        check("stray_done_no_write", 32'(bus_if.tag_wr_en), 0);
        check("stray_done_idle",     32'(bus_if.req_ready), 1);
    endtask

    function automatic logic [31:0] mk_addr(input int tag, input int idx);
        return (32'(tag) << 14) | (32'(idx) << 7) | 32'($urandom_range(0, 127));
    endfunction

    initial begin
        rst                   = 1'b1;
        bus_if.req_valid      = 1'b0;
        bus_if.req_addr       = '0;
        bus_if.fill_req_ready = 1'b0;
        bus_if.fill_done      = 1'b0;
        bus_if.flush          = 1'b0;
        model_clear();
        #2 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, then hit with exact latency.
        lookup(32'h0000_4080, 0, 1'b0);
        lookup(32'h0000_4090, 0, 1'b0);

        // Fill set 1 with tags 2..4, touch tag 1, then tag 5 evicts the PLRU way.
        for (int t = 2; t <= 4; t++) lookup(mk_addr(t, 1), 1, 1'b0);
        lookup(mk_addr(1, 1), 0, 1'b0);
        lookup(mk_addr(5, 1), 0, 1'b0);

        // Flush beats a same-cycle request; tag 1 then misses into way 0.
        do_flush(32'h0000_4080);
        lookup(32'h0000_4080, 0, 1'b0);

        // Fill request held off for five cycles; stray fill_done in IDLE.
        lookup(mk_addr(7, 2), 5, 1'b0);
        stray_done();

        // Reset during MISS_WAIT; same address misses again afterwards.
        lookup(32'h0002_0100, 2, 1'b1);
        lookup(32'h0002_0100, 0, 1'b0);

        // Random traffic over a few sets with more tags than ways.
        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 24));
            if (r == 0)      do_flush(mk_addr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2))));
            else if (r == 1) stray_done();
            else lookup(mk_addr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2))),
                        int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
